program_counter: RTL and testbench

Program counter for the 8-bit CPU, directly downstream of the jump logic in the decoder. On each enabled clock edge it increments for sequential fetch, or loads a branch target when the jump logic asserts its PC-load enable. It also keeps a small return-address stack for CALL/RET. `output_pc` drives the instruction-memory address bus.

---
 rtl/program_counter.sv | 135 +++++++++++++
 tb/tb_program_counter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/program_counter.sv
// Program counter with optional return-address stack for CALL/RET.
// Define PC_STACK_EN to build the stack; otherwise CALL is a plain jump and RET is ignored.
module program_counter #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clock,
    input  logic              input_clear_n,
    input  logic              input_increment,
    input  logic              input_en_pc,
    input  logic [ADDR_W-1:0] input_target,
    input  logic              input_call,
    input  logic              input_return,
    input  logic              input_halt,
    output logic [ADDR_W-1:0] output_pc,
    output logic              output_stack_empty,
    output logic              output_stack_full,
    output logic              output_stack_err
);

    localparam int PTR_W = $clog2(STACK_DEPTH) + 1;
    localparam int IDX_W = PTR_W - 1;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;

    assign output_pc = r_pc;

`ifdef PC_STACK_EN

    logic [ADDR_W-1:0] r_stack [STACK_DEPTH];
    logic [PTR_W-1:0]  r_sp;
    logic [PTR_W-1:0]  w_sp_next;
    logic [PTR_W-1:0]  w_sp_top;
    logic              r_err;
    logic              w_err_next;
    logic              w_push;
    logic              w_empty;
    logic              w_full;

    assign w_empty  = (r_sp == '0);
    assign w_full   = (r_sp == PTR_W'(STACK_DEPTH));
    assign w_sp_top = r_sp - PTR_W'(1);

    always_comb begin
        w_pc_next  = r_pc;
        w_sp_next  = r_sp;
        w_err_next = r_err;
        w_push     = 1'b0;
        if (input_halt) begin
            w_pc_next = r_pc;
        end else if (input_call && input_return) begin
            w_err_next = 1'b1;
        end else if (input_return) begin
            if (w_empty) begin
                w_err_next = 1'b1;
            end else begin
                w_pc_next = r_stack[w_sp_top[IDX_W-1:0]];
                w_sp_next = w_sp_top;
            end
        end else if (input_en_pc) begin
            w_pc_next = input_target;
            if (input_call) begin
                // A call on a full stack still jumps; only the push is lost.
                if (w_full) begin
                    w_err_next = 1'b1;
                end else begin
                    w_push    = 1'b1;
                    w_sp_next = r_sp + PTR_W'(1);
                end
            end
        end else if (input_increment) begin
            w_pc_next = r_pc + ADDR_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!input_clear_n) begin
            r_pc  <= '0;
            r_sp  <= '0;
            r_err <= 1'b0;
        end else begin
            r_pc  <= w_pc_next;
            r_sp  <= w_sp_next;
            r_err <= w_err_next;
        end
    end

    // Entries are not reset; the pointer alone defines which are valid.
    genvar gi;
    generate
        for (gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
            always_ff @(posedge clock) begin
                if (input_clear_n && w_push && (r_sp[IDX_W-1:0] == IDX_W'(gi))) begin
                    r_stack[gi] <= r_pc;
                end
            end
        end
    endgenerate

    assign output_stack_empty = w_empty;
    assign output_stack_full  = w_full;
    assign output_stack_err   = r_err;

`else

    logic w_unused_ok;
    assign w_unused_ok = ^{input_call, input_return};

    always_comb begin
        w_pc_next = r_pc;
        if (input_halt) begin
            w_pc_next = r_pc;
        end else if (input_en_pc) begin
            w_pc_next = input_target;
        end else if (input_increment) begin
            w_pc_next = r_pc + ADDR_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!input_clear_n) begin
            r_pc <= '0;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign output_stack_empty = 1'b1;
    assign output_stack_full  = 1'b0;
    assign output_stack_err   = 1'b0;

`endif

endmodule

// File: tb/tb_program_counter.sv
// Directed-vector bench for program_counter; expectations follow the build's PC_STACK_EN setting.
`timescale 1ns/1ps
module tb_program_counter;

    logic       clock = 1'b0;
    logic       input_clear_n;
    logic       input_increment;
    logic       input_en_pc;
    logic [7:0] input_target;
    logic       input_call;
    logic       input_return;
    logic       input_halt;
    logic [7:0] output_pc;
    logic       output_stack_empty;
    logic       output_stack_full;
    logic       output_stack_err;

    int tests_run = 0;
    int tests_failed = 0;

    program_counter #(.ADDR_W(8), .STACK_DEPTH(4)) dut (
        .clock              (clock),
        .input_clear_n      (input_clear_n),
        .input_increment    (input_increment),
        .input_en_pc        (input_en_pc),
        .input_target       (input_target),
        .input_call         (input_call),
        .input_return       (input_return),
        .input_halt         (input_halt),
        .output_pc          (output_pc),
        .output_stack_empty (output_stack_empty),
        .output_stack_full  (output_stack_full),
        .output_stack_err   (output_stack_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // One edge with the given strobes, then back to idle; outputs sampled 1ns after the edge.
    task automatic cyc(input logic clr_n, input logic inc, input logic en, input logic [7:0] tgt,
                       input logic call, input logic ret, input logic halt);
        input_clear_n   = clr_n;
        input_increment = inc;
        input_en_pc     = en;
        input_target    = tgt;
        input_call      = call;
        input_return    = ret;
        input_halt      = halt;
        @(posedge clock);
        #1;
        input_clear_n   = 1'b1;
        input_increment = 1'b0;
        input_en_pc     = 1'b0;
        input_target    = 8'h00;
        input_call      = 1'b0;
        input_return    = 1'b0;
        input_halt      = 1'b0;
    endtask

    task automatic do_reset();   cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0); endtask
    task automatic do_inc();     cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0); endtask
    task automatic do_jump(input logic [7:0] t); cyc(1'b1, 1'b0, 1'b1, t, 1'b0, 1'b0, 1'b0); endtask
    task automatic do_call(input logic [7:0] t); cyc(1'b1, 1'b0, 1'b1, t, 1'b1, 1'b0, 1'b0); endtask
    task automatic do_ret();     cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0); endtask

    initial begin
        input_clear_n   = 1'b0;
        input_increment = 1'b0;
        input_en_pc     = 1'b0;
        input_target    = 8'h00;
        input_call      = 1'b0;
        input_return    = 1'b0;
        input_halt      = 1'b0;

        do_reset();
        check("reset_pc", output_pc, 8'h00);
        check("reset_empty", output_stack_empty, 1'b1);
        check("reset_full", output_stack_full, 1'b0);
        check("reset_err", output_stack_err, 1'b0);

        for (int i = 1; i <= 3; i++) begin
            do_inc();
            check($sformatf("inc_%0d", i), output_pc, i);
        end

        do_jump(8'hFF);
        check("jump_ff", output_pc, 8'hFF);
        do_inc();
        check("wrap_pc", output_pc, 8'h00);
        check("wrap_err", output_stack_err, 1'b0);

        do_jump(8'h05);
        do_jump(8'h40);
        check("jump_40", output_pc, 8'h40);
        check("jump_empty", output_stack_empty, 1'b1);
        do_jump(8'h05);
        cyc(1'b1, 1'b1, 1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
        check("jump_beats_inc", output_pc, 8'h40);

        cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("halt_inc", output_pc, 8'h40);
        cyc(1'b1, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
        check("halt_jump", output_pc, 8'h40);

`ifdef PC_STACK_EN
        do_jump(8'h10);
        do_call(8'h80);
        check("call_pc", output_pc, 8'h80);
        check("call_empty", output_stack_empty, 1'b0);
        do_ret();
        check("ret_pc", output_pc, 8'h10);
        check("ret_empty", output_stack_empty, 1'b1);

        for (int i = 1; i <= 5; i++) begin
            do_jump(8'(i));
            do_call(8'(8'h10 + i));
            check($sformatf("ncall_pc_%0d", i), output_pc, 8'h10 + i);
            check($sformatf("ncall_full_%0d", i), output_stack_full, (i >= 4) ? 1 : 0);
            check($sformatf("ncall_err_%0d", i), output_stack_err, (i >= 5) ? 1 : 0);
        end
        for (int i = 4; i >= 1; i--) begin
            do_ret();
            check($sformatf("nret_pc_%0d", i), output_pc, i);
            check($sformatf("nret_empty_%0d", i), output_stack_empty, (i == 1) ? 1 : 0);
        end
        do_ret();
        check("under_pc", output_pc, 8'h01);
        check("under_err", output_stack_err, 1'b1);

        do_reset();
        check("clr_pc", output_pc, 8'h00);
        check("clr_err", output_stack_err, 1'b0);
        check("clr_empty", output_stack_empty, 1'b1);

        do_jump(8'h22);
        cyc(1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0);
        check("conflict_pc", output_pc, 8'h22);
        check("conflict_err", output_stack_err, 1'b1);
        check("conflict_empty", output_stack_empty, 1'b1);

        do_reset();
        do_jump(8'h60);
        do_call(8'h70);
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("ret_beats_inc", output_pc, 8'h60);

        do_call(8'h70);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        check("halt_ret_pc", output_pc, 8'h70);
        check("halt_ret_empty", output_stack_empty, 1'b0);
        do_ret();
        check("after_halt_ret", output_pc, 8'h60);

        do_jump(8'h44);
        cyc(1'b1, 1'b0, 1'b0, 8'h99, 1'b1, 1'b0, 1'b0);
        check("call_no_en", output_pc, 8'h44);
        check("call_no_en_empty", output_stack_empty, 1'b1);

        cyc(1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        check("clr_call_pc", output_pc, 8'h00);
        check("clr_call_empty", output_stack_empty, 1'b1);
        do_ret();
        check("clr_call_ret_err", output_stack_err, 1'b1);
        check("clr_call_ret_pc", output_pc, 8'h00);
`else
        do_call(8'h30);
        check("nstk_call_pc", output_pc, 8'h30);
        check("nstk_call_empty", output_stack_empty, 1'b1);
        check("nstk_call_full", output_stack_full, 1'b0);
        do_ret();
        check("nstk_ret_pc", output_pc, 8'h30);
        check("nstk_ret_err", output_stack_err, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("nstk_ret_inc", output_pc, 8'h31);
        cyc(1'b1, 1'b0, 1'b1, 8'h12, 1'b1, 1'b1, 1'b0);
        check("nstk_both_pc", output_pc, 8'h12);
        check("nstk_both_err", output_stack_err, 1'b0);
        do_reset();
        check("nstk_clr_pc", output_pc, 8'h00);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
